lcd_hd44780_responder: RTL

// - Device-side end of the 4-bit HD44780 character-LCD bus (lcd_db/lcd_e/lcd_rs/lcd_rw) that the board top drives.
// - Decodes host strobes into bytes and answers busy-flag/address reads.
// - Delivers each written byte to fabric on a valid/ready stream with a small FIFO.
// - Used for HSMC loopback and in-system checking of the LCD driver; no display RAM is modelled.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_hd44780_responder_if.sv | 22 ++
 rtl/lcd_resp_fifo.sv | 50 +++++
 rtl/lcd_hd44780_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 device-side responder.
package lcd_pkg;

    localparam logic [7:0] CLR       = 8'h01;
    localparam logic [7:0] HOME      = 8'h02;
    localparam logic [7:0] SETDD     = 8'h80;
    localparam logic [7:0] FSET_MASK = 8'hF0;
    localparam logic [7:0] FSET      = 8'h20;
    localparam int unsigned FSET_DL  = 4;

    localparam int unsigned OD_RS    = 15;
    localparam int unsigned OD_ADDR  = 8;
    localparam int unsigned OD_BYTE  = 0;

    typedef enum logic [1:0] {BOOT8, HI, LO} mode_t;

    // Clear and both home encodings (0x02/0x03) take the long busy time.
    function automatic logic is_long(input logic [7:0] b);
        return (b == CLR) || ((b & 8'hFE) == HOME);
    endfunction

    // Function set regardless of the DL bit.
    function automatic logic is_fset(input logic [7:0] b);
        return (b & (FSET_MASK & ~(8'h01 << FSET_DL))) == FSET;
    endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// LCD host bus plus the fabric-side output stream of the responder.
interface lcd_hd44780_responder_if;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [3:0]  lcd_db_i;
    logic [3:0]  lcd_db_o;
    logic        lcd_db_oe;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output lcd_e, lcd_rs, lcd_rw, lcd_db_i, out_ready,
        input  lcd_db_o, lcd_db_oe, out_valid, out_data
    );

    modport slave (
        input  lcd_e, lcd_rs, lcd_rw, lcd_db_i, out_ready,
        output lcd_db_o, lcd_db_oe, out_valid, out_data
    );
endinterface

// File: rtl/lcd_resp_fifo.sv
// Small synchronous FIFO; a push on a full FIFO is dropped unless a pop frees a slot that cycle.
module lcd_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            overflow <= push && !do_push;
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/lcd_hd44780_responder.sv
// Device side of a 4-bit HD44780 bus: assembles host writes into bytes, answers
// busy/address reads, and streams committed bytes to fabric through a FIFO.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 2000,
    parameter int unsigned BUSY_LONG   = 76000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                    sys0_clk,
    input  logic                    sys0_rstn,
    lcd_hd44780_responder_if.slave  bus,
    output logic                    busy,
    output logic [2:0]              stat
);
    localparam int unsigned BMAX = (BUSY_LONG > BUSY_CYCLES) ? BUSY_LONG : BUSY_CYCLES;
    localparam int unsigned CW   = $clog2(BMAX + 1);

    logic [1:0]    e_sync, rs_sync, rw_sync;
    logic [3:0]    db_s1, db_s2;
    logic          e_d, rw_d, rise, fall;
    logic          rs_s, rw_s;
    logic [CW-1:0] busy_cnt;
    logic [6:0]    ac;
    logic [3:0]    hi;
    logic [7:0]    rd_byte;
    logic [3:0]    db_o;
    logic          db_oe;
    mode_t         mode;
    logic          push;
    logic [15:0]   push_data;
    logic          ovf, full, empty;
    logic [7:0]    wr_byte;
    logic          commit;

    assign rs_s          = rs_sync[1];
    assign rw_s          = rw_sync[1];
    assign busy          = (busy_cnt != '0);
    assign bus.lcd_db_o  = db_o;
    assign bus.lcd_db_oe = db_oe;
    assign bus.out_valid = !empty;

    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) begin
            e_sync  <= '0;
            rs_sync <= '0;
            rw_sync <= '0;
            db_s1   <= '0;
            db_s2   <= '0;
            e_d     <= 1'b0;
            rw_d    <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            e_sync  <= {e_sync[0], bus.lcd_e};
            rs_sync <= {rs_sync[0], bus.lcd_rs};
            rw_sync <= {rw_sync[0], bus.lcd_rw};
            db_s1   <= bus.lcd_db_i;
            db_s2   <= db_s1;
            e_d     <= e_sync[1];
            rw_d    <= rw_s;
            rise    <= e_sync[1] & ~e_d;
            fall    <= ~e_sync[1] & e_d;
        end
    end

    // In 8-bit boot mode each strobe is a whole byte carried on DB[7:4].
    always_comb begin
        wr_byte = (mode == BOOT8) ? {db_s2, 4'h0} : {hi, db_s2};
        commit  = fall && !rw_s && (mode != HI);
    end

    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) begin
            mode      <= BOOT8;
            hi        <= '0;
            ac        <= '0;
            busy_cnt  <= '0;
            stat      <= '0;
            rd_byte   <= '0;
            db_o      <= '0;
            db_oe     <= 1'b0;
            push      <= 1'b0;
            push_data <= '0;
        end else begin
            push <= 1'b0;
            if (busy_cnt != '0) busy_cnt <= busy_cnt - CW'(1);
            if (ovf) stat[1] <= 1'b1;

            if (fall && !rw_s && mode == HI) begin
                hi   <= db_s2;
                mode <= LO;
            end

            if (commit) begin
                if (busy) stat[2] <= 1'b1;
                busy_cnt <= (!rs_s && is_long(wr_byte)) ? CW'(BUSY_LONG) : CW'(BUSY_CYCLES);
                if (rs_s)                      ac <= ac + 7'd1;
                else if (is_long(wr_byte))     ac <= '0;
                else if ((wr_byte & SETDD) != '0) ac <= wr_byte[6:0];

                if (mode == LO) begin
                    push                   <= 1'b1;
                    push_data[OD_RS]       <= rs_s;
                    push_data[OD_ADDR +: 7] <= ac;
                    push_data[OD_BYTE +: 8] <= wr_byte;
                    mode                   <= HI;
                    if (!rs_s && is_fset(wr_byte) && wr_byte[FSET_DL]) begin
                        mode    <= BOOT8;
                        stat[0] <= 1'b0;
                    end
                end else if (!rs_s && is_fset(wr_byte) && !wr_byte[FSET_DL]) begin
                    mode    <= HI;
                    stat[0] <= 1'b1;
                end
            end

            // Capture the whole read byte on the high-nibble rise so both halves agree.
            if (rise && rw_s) begin
                db_oe <= 1'b1;
                if (mode == LO) begin
                    db_o <= rd_byte[3:0];
                end else begin
                    rd_byte <= rs_s ? 8'h00 : {busy, ac};
                    db_o    <= rs_s ? 4'h0 : {busy, ac[6:4]};
                end
            end

            if (fall && rw_s) begin
                db_oe <= 1'b0;
                if (mode == HI)      mode <= LO;
                else if (mode == LO) mode <= HI;
            end

            if (rw_d && !rw_s && db_oe) db_oe <= 1'b0;
        end
    end

    lcd_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (sys0_clk),
        .rst_n     (sys0_rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.out_ready),
        .head      (bus.out_data),
        .full      (full),
        .empty     (empty),
        .overflow  (ovf)
    );

    logic unused_full;
    assign unused_full = full;
endmodule
